// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: tracks in-flight register writes and generates forwarding selects and load-use stalls
module forwarding_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic                       id_we,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic [SEL_W-1:0]           id_lat,
    input  logic                       hold,
    input  logic                       flush,
    output logic                       stall,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel
);
    logic [DEPTH:1]       r_v;
    logic [DEPTH:1]       r_we;
    logic [REG_AW-1:0]    r_rd  [1:DEPTH];
    logic [SEL_W-1:0]     r_lat [1:DEPTH];
    logic [NUM_SRC-1:0]       w_haz;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic                     w_issue;

    // Youngest match per source: scan oldest to youngest so the smallest stage index wins
    always_comb begin
        w_haz = '0;
        w_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = DEPTH; j >= 1; j--) begin
                if (id_rs_used[i] && id_rs[i*REG_AW +: REG_AW] != '0 && r_v[j] && r_we[j] &&
                    r_rd[j] == id_rs[i*REG_AW +: REG_AW]) begin
                    w_sel[i*SEL_W +: SEL_W] = SEL_W'(j);
                    w_haz[i] = SEL_W'(j) < ((r_lat[j] == '0) ? SEL_W'(1) : r_lat[j]);
                end
            end
        end
    end

    assign stall   = id_valid & ~flush & (|w_haz);
    assign w_issue = id_valid & ~stall & ~flush;

    // Scoreboard shift and registered select; everything frozen while hold is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_we    <= '0;
            fwd_sel <= '0;
            for (int j = 1; j <= DEPTH; j++) begin
                r_rd[j]  <= '0;
                r_lat[j] <= '0;
            end
        end else if (!hold) begin
            for (int j = DEPTH; j >= 2; j--) begin
                r_v[j]   <= r_v[j-1];
                r_we[j]  <= r_we[j-1];
                r_rd[j]  <= r_rd[j-1];
                r_lat[j] <= r_lat[j-1];
            end
            r_v[1]   <= w_issue;
            r_we[1]  <= id_we;
            r_rd[1]  <= id_rd;
            r_lat[1] <= id_lat;
            fwd_sel  <= w_issue ? w_sel : '0;
        end
    end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb_forwarding_scoreboard: directed scenarios plus randomized run against a queue-based reference model
module tb_forwarding_scoreboard;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       id_valid = 0;
    logic [9:0] id_rs = '0;
    logic [1:0] id_rs_used = '0;
    logic       id_we = 0;
    logic [4:0] id_rd = '0;
    logic [1:0] id_lat = '0;
    logic       hold = 0;
    logic       flush = 0;
    logic       stall;
    logic [3:0] fwd_sel;

    logic       d4_valid = 0;
    logic [9:0] d4_rs = '0;
    logic [1:0] d4_used = '0;
    logic       d4_we = 0;
    logic [4:0] d4_rd = '0;
    logic [2:0] d4_lat = '0;
    logic       d4_stall;
    logic [5:0] d4_fwd;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {logic v; logic we; logic [4:0] rd; logic [1:0] lat;} ent_t;
    ent_t       hist[$];
    logic [3:0] exp_fwd = '0;

    forwarding_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_we(id_we), .id_rd(id_rd), .id_lat(id_lat), .hold(hold), .flush(flush),
        .stall(stall), .fwd_sel(fwd_sel)
    );

    forwarding_scoreboard #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(d4_valid), .id_rs(d4_rs), .id_rs_used(d4_used),
        .id_we(d4_we), .id_rd(d4_rd), .id_lat(d4_lat), .hold(1'b0), .flush(1'b0),
        .stall(d4_stall), .fwd_sel(d4_fwd)
    );

    always #5 clk = ~clk;

    // Reference: the queue holds the most recent EX entries, youngest first
    function automatic void model_eval(output logic st, output logic [3:0] sels);
        logic haz = 0;
        int   leff;
        sels = '0;
        for (int i = 0; i < 2; i++) begin
            logic [4:0] rs = id_rs[i*5 +: 5];
            if (!id_rs_used[i] || rs == 0) continue;
            for (int k = 0; k < hist.size(); k++) begin
                if (hist[k].v && hist[k].we && hist[k].rd == rs) begin
                    leff = (hist[k].lat == 0) ? 1 : int'(hist[k].lat);
                    if (k + 1 < leff) haz = 1;
                    else sels[i*2 +: 2] = 2'(k + 1);
                    break;
                end
            end
        end
        st = id_valid & ~flush & haz;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_fwd = '0;
    endtask

    task automatic tick();
        logic       st;
        logic [3:0] sels;
        logic       iss;
        ent_t       e;
        model_eval(st, sels);
        iss = id_valid & ~st & ~flush;
        @(posedge clk);
        if (!hold) begin
            e.v = iss; e.we = id_we; e.rd = id_rd; e.lat = id_lat;
            hist.push_front(e);
            if (hist.size() > 2) void'(hist.pop_back());
            exp_fwd = iss ? sels : 4'b0;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] used, input logic we, input logic [4:0] rd, input logic [1:0] lat);
        id_valid = v; id_rs = {rs2, rs1}; id_rs_used = used; id_we = we; id_rd = rd; id_lat = lat;
    endtask

    task automatic clear();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 2'b00, 1, 5, 1);
        tick();
        drive(1, 5, 0, 2'b01, 1, 5, 2);
        tick();
        n_tests++;
        if (fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL reset_pre_fwd got=%h want=1", fwd_sel); end
        drive(1, 5, 0, 2'b01, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_pre_stall got=%b want=1", stall); end
        #2 rst_n = 0;
        #1;
        model_reset();
        n_tests++;
        if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL reset_async_fwd got=%h want=0", fwd_sel); end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_async_stall got=%b want=0", stall); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_after_stall got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL reset_after_fwd got=%h want=0", fwd_sel); end
    endtask

    task automatic test_alu_chain();
        clear();
        drive(1, 0, 0, 2'b00, 1, 5, 1);
        tick();
        drive(1, 5, 0, 2'b01, 1, 6, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel[1:0] !== 2'd1) begin n_fail++; $display("FAIL alu_sel1 got=%0d want=1", fwd_sel[1:0]); end
        drive(1, 5, 0, 2'b01, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall2 got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL alu_sel2 got=%0d want=2", fwd_sel[1:0]); end
    endtask

    task automatic test_load_use();
        clear();
        drive(1, 0, 0, 2'b00, 1, 7, 2);
        tick();
        drive(1, 9, 7, 2'b11, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b want=1", stall); end
        tick();
        n_tests++;
        if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL lu_bubble_fwd got=%h want=0", fwd_sel); end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL lu_sel got=%h want=8", fwd_sel); end
    endtask

    task automatic test_youngest();
        clear();
        drive(1, 0, 0, 2'b00, 1, 3, 1);
        tick();
        drive(1, 0, 0, 2'b00, 1, 3, 2);
        tick();
        drive(1, 3, 0, 2'b01, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL young_stall got=%b want=1", stall); end
        tick();
        n_tests++;
        if (fwd_sel[1:0] !== 2'd0) begin n_fail++; $display("FAIL young_first got=%0d want=0", fwd_sel[1:0]); end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL young_stall_end got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL young_sel got=%0d want=2", fwd_sel[1:0]); end
    endtask

    task automatic test_null();
        clear();
        drive(1, 0, 0, 2'b00, 1, 0, 2);
        tick();
        drive(1, 0, 0, 2'b01, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL null_x0_stall got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL null_x0_fwd got=%h want=0", fwd_sel); end
        drive(1, 0, 0, 2'b00, 1, 4, 2);
        tick();
        drive(1, 0, 4, 2'b01, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL null_unused_stall got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL null_unused_fwd got=%h want=0", fwd_sel); end
    endtask

    task automatic test_hold_flush();
        clear();
        drive(1, 0, 0, 2'b00, 1, 2, 1);
        tick();
        drive(1, 2, 0, 2'b01, 1, 7, 2);
        tick();
        drive(1, 0, 7, 2'b10, 1, 7, 2);
        hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall c=%0d got=%b want=1", c, stall); end
            tick();
            n_tests++;
            if (fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL hold_fwd c=%0d got=%h want=1", c, fwd_sel); end
        end
        hold = 0;
        flush = 1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b want=0", stall); end
        tick();
        flush = 0;
        n_tests++;
        if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL flush_fwd got=%h want=0", fwd_sel); end
        drive(1, 0, 7, 2'b10, 0, 0, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_bubble_stall got=%b want=0", stall); end
        tick();
        n_tests++;
        if (fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL flush_after_sel got=%h want=8", fwd_sel); end
    endtask

    task automatic test_deep();
        clear();
        d4_valid = 1; d4_rs = '0; d4_used = 0; d4_we = 1; d4_rd = 9; d4_lat = 4;
        tick();
        d4_rs = {5'd0, 5'd9}; d4_used = 2'b01; d4_we = 0; d4_rd = 0; d4_lat = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (d4_stall !== 1'b1) begin n_fail++; $display("FAIL deep_stall c=%0d got=%b want=1", c, d4_stall); end
            tick();
        end
        #1;
        n_tests++;
        if (d4_stall !== 1'b0) begin n_fail++; $display("FAIL deep_stall_end got=%b want=0", d4_stall); end
        tick();
        n_tests++;
        if (d4_fwd[2:0] !== 3'd4) begin n_fail++; $display("FAIL deep_sel got=%0d want=4", d4_fwd[2:0]); end
        d4_valid = 0;
    endtask

    task automatic test_random();
        logic       st;
        logic [3:0] sels;
        clear();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom));
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            #1;
            model_eval(st, sels);
            n_tests++;
            if (stall !== st) begin n_fail++; $display("FAIL rand_stall c=%0d got=%b want=%b", c, stall, st); end
            tick();
            n_tests++;
            if (fwd_sel !== exp_fwd) begin n_fail++; $display("FAIL rand_fwd c=%0d got=%h want=%h", c, fwd_sel, exp_fwd); end
        end
        hold = 0;
        flush = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest();
        test_null();
        test_hold_flush();
        test_deep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
